// File: rtl/hdlverifier_capture_pkg.sv
// Shared definitions for the capture write controller: FSM state encoding
// and a small helper that classifies states.
package hdlverifier_capture_pkg;

    // State encoding kept as plain localparams so older tools and
    // existing RTL that compare against raw codes keep working.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRE_FILL  = 3'd1;
    localparam logic [2:0] WAIT_TRIG = 3'd2;
    localparam logic [2:0] POST      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    // True for the states in which samples are accepted and written.
    function automatic logic is_busy(input logic [2:0] st);
        return (st == PRE_FILL) || (st == WAIT_TRIG) || (st == POST);
    endfunction

endpackage

// File: rtl/hdlverifier_capture_ctrl.sv
// Capture write controller. Converts a qualified sample stream plus a
// trigger into circular-buffer RAM writes with a programmable pre-trigger
// window, and reports the address of the oldest retained sample once the
// buffer is complete. All outputs are registered.
module hdlverifier_capture_ctrl
    import hdlverifier_capture_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pretrig_depth,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  trigger_in,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    // Counters need one extra bit: P and R can each reach DEPTH-1 and the
    // remaining-count arithmetic starts from DEPTH itself.
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] pdepth_q, pdepth_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         remain;

    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  trig_q, trig_d;
    logic                  done_q, done_d;

    // Samples still to come after the trigger sample itself.
    assign remain = DEPTH_C - {1'b0, pdepth_q} - ONE_C;

    // Next-state logic: FSM, write pointer, counters and registered outputs.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pdepth_d = pdepth_q;
        cnt_d    = cnt_q;
        wr_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        start_d  = start_q;
        trig_d   = trig_q;
        done_d   = done_q;

        // Any accepted sample is written at the pointer, pointer advances.
        if (!abort && is_busy(state_q) && data_valid) begin
            wr_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = data_in;
            ptr_d   = ptr_q + 1'b1;
        end

        if (abort) begin
            // Abort wins over arm and drops the sample of this cycle.
            state_d = IDLE;
            trig_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        pdepth_d = pretrig_depth;
                        cnt_d    = {1'b0, pretrig_depth};
                        ptr_d    = '0;
                        start_d  = '0;
                        trig_d   = 1'b0;
                        done_d   = 1'b0;
                        state_d  = (pretrig_depth != '0) ? PRE_FILL : WAIT_TRIG;
                    end else if (state_q == DONE) begin
                        // One cycle in DONE lets the last RAM write land.
                        done_d = 1'b1;
                    end
                end
                PRE_FILL: begin
                    if (data_valid) begin
                        if (cnt_q == ONE_C) begin
                            state_d = WAIT_TRIG;
                        end else begin
                            cnt_d = cnt_q - ONE_C;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (data_valid && trigger_in) begin
                        start_d = ptr_q - pdepth_q;
                        trig_d  = 1'b1;
                        cnt_d   = remain;
                        state_d = (remain == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (data_valid) begin
                        if (cnt_q == ONE_C) begin
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q - ONE_C;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = is_busy(state_d);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            pdepth_q <= '0;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            start_q  <= '0;
            busy_q   <= 1'b0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            pdepth_q <= pdepth_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            trig_q   <= trig_d;
            done_q   <= done_d;
        end
    end

    assign wr         = wr_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign start_addr = start_q;
    assign busy       = busy_q;
    assign triggered  = trig_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hdlverifier_capture_ctrl.sv
// Directed bench for the capture write controller. A negedge monitor
// mirrors RAM writes into a local array and records pulse timing; each test
// task drives a capture and compares against hand-computed results.
module tb_hdlverifier_capture_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] pretrig_depth = '0;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       trigger_in = 1'b0;
    logic       wr;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic [4:0] start_addr;
    logic       busy;
    logic       triggered;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor state
    bit         mon_clr = 1'b0;
    int         wr_cnt = 0;
    int         last_wr_cyc = 0;
    int         done_cyc = 0;
    logic [7:0] last_wr_data = '0;
    logic [4:0] first_waddr = '0;
    bit         trig_seen = 1'b0;
    bit         trig_wr = 1'b0;
    logic [7:0] trig_data = '0;
    bit         done_seen = 1'b0;
    logic [7:0] mem [32];

    hdlverifier_capture_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .abort        (abort),
        .pretrig_depth(pretrig_depth),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .trigger_in   (trigger_in),
        .wr           (wr),
        .waddr        (waddr),
        .wdata        (wdata),
        .start_addr   (start_addr),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mirror RAM writes and record trigger/done timing, mid-cycle.
    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt    = 0;
            trig_seen = 1'b0;
            done_seen = 1'b0;
        end else begin
            if (wr) begin
                if (wr_cnt == 0) first_waddr = waddr;
                wr_cnt       = wr_cnt + 1;
                mem[waddr]   = wdata;
                last_wr_cyc  = cyc;
                last_wr_data = wdata;
            end
            if (triggered && !trig_seen) begin
                trig_seen = 1'b1;
                trig_wr   = wr;
                trig_data = wdata;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    // Arm with depth p (a valid, triggering sample sits on the arm cycle and
    // must not be captured), then stream 0,1,2.. until done or maxc cycles.
    task automatic stream(input int p, input int tv, input bit toggle, input bit early,
                          input int arm_at, input int abort_at, input int maxc);
        int d;
        bit v;
        arm = 1'b1;
        pretrig_depth = 5'(p);
        mon_clr = 1'b1;
        data_valid = 1'b1;
        data_in = 8'hEE;
        trigger_in = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        mon_clr = 1'b0;
        d = 0;
        for (int k = 0; k < maxc && !done_seen; k++) begin
            v = !toggle || (k % 2 == 0);
            arm = (k == arm_at);
            pretrig_depth = (k == arm_at) ? 5'd0 : 5'(p);
            abort = (k == abort_at);
            data_valid = v;
            data_in = 8'(d);
            trigger_in = v ? ((d == tv) || (early && d < 31)) : toggle;
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                abort = 1'b0;
                break;
            end
            if (v) d++;
        end
        arm = 1'b0;
        // Valid samples presented while DONE must not be written.
        if (done_seen) begin
            for (int k = 0; k < 3; k++) begin
                data_valid = 1'b1;
                data_in = 8'hA0 + 8'(k);
                trigger_in = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        data_valid = 1'b0;
        trigger_in = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({wr, waddr, wdata, start_addr, busy, triggered, done} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {wr, waddr, wdata, start_addr, busy, triggered, done});
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({wr, busy, done} !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: wr/busy/done=%b expected 000", {wr, busy, done});
        end
    endtask

    task automatic test_p8();
        stream(8, 20, 1'b0, 1'b0, -1, -1, 200);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL p8_timeout: done never rose"); end
        checks++;
        if (wr_cnt !== 44) begin errors++; $display("FAIL p8_wr_count: got %0d expected 44", wr_cnt); end
        checks++;
        if (start_addr !== 5'd12) begin
            errors++; $display("FAIL p8_start_addr: got %0d expected 12", start_addr);
        end
        checks++;
        if (last_wr_data !== 8'd43) begin
            errors++; $display("FAIL p8_last_data: got %0d expected 43", last_wr_data);
        end
        checks++;
        if (done_cyc !== last_wr_cyc + 1) begin
            errors++; $display("FAIL p8_done_timing: done cyc %0d expected %0d", done_cyc, last_wr_cyc + 1);
        end
        checks++;
        if (!(trig_wr && trig_data == 8'd20)) begin
            errors++; $display("FAIL p8_trig: wr=%b data=%0d expected wr=1 data=20", trig_wr, trig_data);
        end
        checks++;
        if ({busy, triggered, done} !== 3'b011) begin
            errors++; $display("FAIL p8_flags: busy/trig/done=%b expected 011", {busy, triggered, done});
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[(12 + i) % 32] !== 8'(12 + i)) begin
                errors++;
                $display("FAIL p8_mem[%0d]: got %0d expected %0d", (12 + i) % 32, mem[(12 + i) % 32], 12 + i);
            end
        end
    endtask

    task automatic test_p0();
        stream(0, 0, 1'b0, 1'b0, -1, -1, 200);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL p0_timeout: done never rose"); end
        checks++;
        if (wr_cnt !== 32) begin errors++; $display("FAIL p0_wr_count: got %0d expected 32", wr_cnt); end
        checks++;
        if (start_addr !== 5'd0) begin
            errors++; $display("FAIL p0_start_addr: got %0d expected 0", start_addr);
        end
        checks++;
        if (!(trig_wr && trig_data == 8'd0 && first_waddr == 5'd0)) begin
            errors++;
            $display("FAIL p0_trig_first_wr: wr=%b data=%0d addr=%0d expected 1/0/0",
                     trig_wr, trig_data, first_waddr);
        end
        checks++;
        if (done_cyc !== last_wr_cyc + 1) begin
            errors++; $display("FAIL p0_done_timing: done cyc %0d expected %0d", done_cyc, last_wr_cyc + 1);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[i] !== 8'(i)) begin
                errors++; $display("FAIL p0_mem[%0d]: got %0d expected %0d", i, mem[i], i);
            end
        end
    endtask

    task automatic test_p31();
        stream(31, 40, 1'b0, 1'b1, -1, -1, 200);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL p31_timeout: done never rose"); end
        checks++;
        if (wr_cnt !== 41) begin errors++; $display("FAIL p31_wr_count: got %0d expected 41", wr_cnt); end
        checks++;
        if (start_addr !== 5'd9) begin
            errors++; $display("FAIL p31_start_addr: got %0d expected 9", start_addr);
        end
        checks++;
        if (!(trig_wr && trig_data == 8'd40)) begin
            errors++; $display("FAIL p31_trig: wr=%b data=%0d expected wr=1 data=40", trig_wr, trig_data);
        end
        checks++;
        if (last_wr_data !== 8'd40 || done_cyc !== last_wr_cyc + 1) begin
            errors++;
            $display("FAIL p31_done: last data %0d done cyc %0d expected 40 and %0d",
                     last_wr_data, done_cyc, last_wr_cyc + 1);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[(9 + i) % 32] !== 8'(9 + i)) begin
                errors++;
                $display("FAIL p31_mem[%0d]: got %0d expected %0d", (9 + i) % 32, mem[(9 + i) % 32], 9 + i);
            end
        end
    endtask

    task automatic test_toggle_valid();
        stream(4, 10, 1'b1, 1'b0, -1, -1, 200);
        checks++;
        if (!done_seen) begin errors++; $display("FAIL tog_timeout: done never rose"); end
        checks++;
        if (wr_cnt !== 38) begin errors++; $display("FAIL tog_wr_count: got %0d expected 38", wr_cnt); end
        checks++;
        if (start_addr !== 5'd6) begin
            errors++; $display("FAIL tog_start_addr: got %0d expected 6", start_addr);
        end
        checks++;
        if (!(trig_wr && trig_data == 8'd10)) begin
            errors++; $display("FAIL tog_trig: wr=%b data=%0d expected wr=1 data=10", trig_wr, trig_data);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[(6 + i) % 32] !== 8'(6 + i)) begin
                errors++;
                $display("FAIL tog_mem[%0d]: got %0d expected %0d", (6 + i) % 32, mem[(6 + i) % 32], 6 + i);
            end
        end
    endtask

    task automatic test_abort();
        int n;
        // P=2, trigger on 5, abort while sample 8 is presented in POST.
        stream(2, 5, 1'b0, 1'b0, -1, 8, 200);
        checks++;
        if ({busy, triggered, done, wr} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_flags: busy/trig/done/wr=%b expected 0000", {busy, triggered, done, wr});
        end
        checks++;
        if (wr_cnt !== 8) begin errors++; $display("FAIL abort_wr_count: got %0d expected 8", wr_cnt); end
        n = wr_cnt;
        for (int k = 0; k < 5; k++) begin
            data_valid = 1'b1;
            data_in = 8'h30 + 8'(k);
            trigger_in = 1'b1;
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        trigger_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wr_cnt !== n) begin
            errors++; $display("FAIL abort_no_wr: got %0d writes expected %0d", wr_cnt, n);
        end
    endtask

    task automatic test_arm_busy();
        // P=3, a second arm with depth 0 two cycles in must be ignored.
        stream(3, 10, 1'b0, 1'b0, 2, -1, 200);
        checks++;
        if (first_waddr !== 5'd0) begin
            errors++; $display("FAIL rearm_waddr: got %0d expected 0", first_waddr);
        end
        checks++;
        if (wr_cnt !== 39) begin errors++; $display("FAIL armbusy_wr_count: got %0d expected 39", wr_cnt); end
        checks++;
        if (start_addr !== 5'd7) begin
            errors++; $display("FAIL armbusy_start_addr: got %0d expected 7", start_addr);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[(7 + i) % 32] !== 8'(7 + i)) begin
                errors++;
                $display("FAIL armbusy_mem[%0d]: got %0d expected %0d", (7 + i) % 32, mem[(7 + i) % 32], 7 + i);
            end
        end
    endtask

    task automatic test_reset_mid_post();
        int n;
        stream(8, 20, 1'b0, 1'b0, -1, -1, 26);
        data_valid = 1'b1;
        data_in = 8'h55;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({wr, waddr, wdata, start_addr, busy, triggered, done} !== 23'd0) begin
            errors++;
            $display("FAIL midpost_reset_outputs: got %h expected 0",
                     {wr, waddr, wdata, start_addr, busy, triggered, done});
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        n = wr_cnt;
        for (int k = 0; k < 6; k++) begin
            data_valid = 1'b1;
            data_in = 8'(k);
            trigger_in = 1'b1;
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        trigger_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wr_cnt !== n || busy !== 1'b0) begin
            errors++;
            $display("FAIL midpost_after_release: writes %0d busy %b expected %0d and 0", wr_cnt, busy, n);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'hXX;
        test_reset();
        test_p8();
        test_p0();
        test_p31();
        test_toggle_valid();
        test_abort();
        test_arm_busy();
        test_reset_mid_post();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
